ifm_rx_ingress: RTL
===================

Name: ifm_rx_ingress

Overview:
- Parametrised RX ingress stage between the MAC receive AXI-Stream and the RX data/info FIFOs.
- Writes each accepted frame beat-by-beat into the data FIFO. Writes one status word per frame into the info FIFO: byte length, bad flag, truncated flag.
- Drops whole frames when either FIFO is almost full at frame start.
- Truncates frames longer than C_MAX_FRAME and keeps saturating frame/drop statistics.

Parameters:
- C_DATA_WIDTH, 64, stream data width in bits; 64 or 32 only.
- C_KEEP_WIDTH, C_DATA_WIDTH/8, derived byte-enable width; not overridden.
- C_LEN_WIDTH, 14, frame length field width. Must hold C_MAX_FRAME+C_KEEP_WIDTH.
- C_MAX_FRAME, 9018, maximum accepted frame length in bytes.
- C_CNT_WIDTH, 32, statistics counter width.

Ports:
- rx_clk  in  1  clock; all logic on rising edge.
- rx_reset_n  in  1  asynchronous, active-low reset.
- rx_axis_mac_tdata  in  C_DATA_WIDTH  frame data.
- rx_axis_mac_tkeep  in  C_KEEP_WIDTH  byte enables; contiguous from bit 0.
- rx_axis_mac_tlast  in  1  last beat of frame.
- rx_axis_mac_tuser  in  1  frame good (1) / bad (0); valid on the tlast beat.
- rx_axis_mac_tvalid  in  1  beat valid.
- rx_axis_mac_tready  out  1  beat accept.
- data_fifo_wdata  out  C_DATA_WIDTH+C_KEEP_WIDTH+1  {tlast, tkeep, tdata}, MSB first.
- data_fifo_wren  out  1  data FIFO write strobe.
- data_fifo_afull  in  1  data FIFO almost full.
- info_fifo_wdata  out  C_LEN_WIDTH+2  {trunc, bad, len}.
- info_fifo_wren  out  1  info FIFO write strobe.
- info_fifo_afull  in  1  info FIFO almost full.
- stat_clr  in  1  synchronous clear of both counters.
- stat_frame_cnt  out  C_CNT_WIDTH  frames delivered (info words written).
- stat_drop_cnt  out  C_CNT_WIDTH  frames dropped at start.

Behaviour:
Reset values (async, while rx_reset_n=0):
- All outputs 0, including rx_axis_mac_tready.
- State is S_SYNC.
- tready goes to 1 on the first clock after reset release and stays 1; the block never backpressures.

Beat definition: beat = tvalid & tready.

Output timing:
- All FIFO outputs are registered.
- wren/wdata appear exactly 1 cycle after the beat.
- wren is 0 in cycles with no beat.

States:
- S_SYNC: discard beats, no writes. Go to S_IDLE on a beat with tlast. A frame in progress at reset release is therefore never partially written. If the MAC is idle at reset release, the first frame is also consumed by S_SYNC; this is accepted.
- S_IDLE, on a beat:
  - If data_fifo_afull | info_fifo_afull: no write; stat_drop_cnt += 1; go to S_DROP, or stay in S_IDLE if the beat has tlast.
  - Otherwise: write the beat; len = popcount(tkeep). If tlast, write info and stay in S_IDLE; else go to S_PASS.
- S_PASS, on a beat:
  - Compute len_next = len + popcount(tkeep).
  - If len_next > C_MAX_FRAME: write the beat with the tlast field forced to 1; write info {1,1,len_next}; go to S_TRUNC (S_IDLE if the beat itself has tlast).
  - Else: write the beat; len = len_next. On tlast, write info {0, ~tuser, len_next} and go to S_IDLE.
- S_DROP / S_TRUNC: discard beats; go to S_IDLE on the tlast beat.

Invariants:
- afull is sampled only on the first beat of a frame. A frame that started is always completed in the data FIFO with exactly one tlast word and exactly one info word; downstream relies on this.
- Single-beat frames (tlast on first beat) produce one data write and one info write in the same cycle.
- Gaps with tvalid=0 inside a frame hold state and len.

Counters:
- stat_frame_cnt += 1 on each info write.
- Both counters saturate at all-ones.
- stat_clr forces 0; clear wins over a simultaneous increment.

Test Plan:
- Reset release mid-frame: 3 beats then tlast, then a 64-byte frame (8 beats, keep=FF) -> no writes for the first frame. The second frame gives 8 data writes, info=0x0040 with bad=0, trunc=0, tuser=1, and stat_frame_cnt=1.
- Odd length: a 61-byte frame (last keep=0x1F) with tuser=0 -> last data word keep=1F, tlast=1; info len=61, bad=1, trunc=0.
- Drop: data_fifo_afull=1 on the first beat, deasserted mid-frame -> zero writes for the frame; stat_drop_cnt=1. The next frame is written normally.
- Truncation: C_MAX_FRAME=9018, a 9100-byte frame -> the beat reaching 9024 bytes is written with tlast=1; info {trunc=1, bad=1, len=9024}; the remaining beats are discarded; the next frame is intact.
- Single-beat frame, keep=0x3F, tvalid gaps inside a multi-beat frame -> one data write plus one info in the same cycle, len=6. Gaps produce no writes and preserve the length count.
- Counter edge cases: stat_clr in the same cycle as an info write -> stat_frame_cnt=0. Preloading all-ones (C_CNT_WIDTH=4, 15 frames plus 1) -> the counter holds at 15.

Source files
------------

// File: rtl/ifm_rx_ingress.sv
// RX ingress stage: moves MAC receive beats into the RX data FIFO and emits
// one {trunc, bad, len} status word per frame into the RX info FIFO.
// Whole frames are dropped when either FIFO is almost full at frame start;
// frames longer than C_MAX_FRAME are cut short with a forced tlast word.
module ifm_rx_ingress #(
    parameter int C_DATA_WIDTH = 64,
    parameter int C_KEEP_WIDTH = C_DATA_WIDTH / 8,
    parameter int C_LEN_WIDTH  = 14,
    parameter int C_MAX_FRAME  = 9018,
    parameter int C_CNT_WIDTH  = 32
) (
    input  logic                                rx_clk,
    input  logic                                rx_reset_n,
    input  logic [C_DATA_WIDTH-1:0]             rx_axis_mac_tdata,
    input  logic [C_KEEP_WIDTH-1:0]             rx_axis_mac_tkeep,
    input  logic                                rx_axis_mac_tlast,
    input  logic                                rx_axis_mac_tuser,
    input  logic                                rx_axis_mac_tvalid,
    output logic                                rx_axis_mac_tready,
    output logic [C_DATA_WIDTH+C_KEEP_WIDTH:0]  data_fifo_wdata,
    output logic                                data_fifo_wren,
    input  logic                                data_fifo_afull,
    output logic [C_LEN_WIDTH+1:0]              info_fifo_wdata,
    output logic                                info_fifo_wren,
    input  logic                                info_fifo_afull,
    input  logic                                stat_clr,
    output logic [C_CNT_WIDTH-1:0]              stat_frame_cnt,
    output logic [C_CNT_WIDTH-1:0]              stat_drop_cnt
);

    localparam int POP_W = $clog2(C_KEEP_WIDTH + 1);

    typedef enum logic [2:0] {
        S_SYNC,
        S_IDLE,
        S_PASS,
        S_DROP,
        S_TRUNC
    } state_t;

    state_t                 state;
    logic [C_LEN_WIDTH-1:0] len;
    logic [POP_W-1:0]       pop;
    logic [C_LEN_WIDTH-1:0] len_first;
    logic [C_LEN_WIDTH-1:0] len_next;
    logic                   over;
    logic                   beat;
    logic                   afull_any;
    logic                   drop_inc;

    assign beat      = rx_axis_mac_tvalid & rx_axis_mac_tready;
    assign afull_any = data_fifo_afull | info_fifo_afull;
    assign len_first = C_LEN_WIDTH'(pop);
    assign len_next  = len + C_LEN_WIDTH'(pop);
    assign over      = len_next > C_LEN_WIDTH'(C_MAX_FRAME);
    assign drop_inc  = beat & (state == S_IDLE) & afull_any;

    // Byte count of the current beat; tkeep is contiguous so a popcount is the length.
    always_comb begin
        pop = '0;
        for (int i = 0; i < C_KEEP_WIDTH; i++)
            pop = pop + POP_W'(rx_axis_mac_tkeep[i]);
    end

    // Frame FSM with registered FIFO write ports; tready rises once after reset and stays up.
    always_ff @(posedge rx_clk or negedge rx_reset_n) begin
        if (!rx_reset_n) begin
            state              <= S_SYNC;
            len                <= '0;
            rx_axis_mac_tready <= 1'b0;
            data_fifo_wren     <= 1'b0;
            data_fifo_wdata    <= '0;
            info_fifo_wren     <= 1'b0;
            info_fifo_wdata    <= '0;
        end else begin
            rx_axis_mac_tready <= 1'b1;
            data_fifo_wren     <= 1'b0;
            info_fifo_wren     <= 1'b0;
            if (beat) begin
                case (state)
                    // Swallow whatever frame may be in flight at reset release.
                    S_SYNC: begin
                        if (rx_axis_mac_tlast) state <= S_IDLE;
                    end
                    // First beat: the only place afull is honoured.
                    S_IDLE: begin
                        if (afull_any) begin
                            if (!rx_axis_mac_tlast) state <= S_DROP;
                        end else begin
                            data_fifo_wren  <= 1'b1;
                            data_fifo_wdata <= {rx_axis_mac_tlast, rx_axis_mac_tkeep, rx_axis_mac_tdata};
                            len             <= len_first;
                            if (rx_axis_mac_tlast) begin
                                info_fifo_wren  <= 1'b1;
                                info_fifo_wdata <= {1'b0, ~rx_axis_mac_tuser, len_first};
                            end else begin
                                state <= S_PASS;
                            end
                        end
                    end
                    // Body beats: the beat that crosses the limit closes the frame early.
                    S_PASS: begin
                        data_fifo_wren <= 1'b1;
                        if (over) begin
                            data_fifo_wdata <= {1'b1, rx_axis_mac_tkeep, rx_axis_mac_tdata};
                            info_fifo_wren  <= 1'b1;
                            info_fifo_wdata <= {2'b11, len_next};
                            state           <= rx_axis_mac_tlast ? S_IDLE : S_TRUNC;
                        end else begin
                            data_fifo_wdata <= {rx_axis_mac_tlast, rx_axis_mac_tkeep, rx_axis_mac_tdata};
                            len             <= len_next;
                            if (rx_axis_mac_tlast) begin
                                info_fifo_wren  <= 1'b1;
                                info_fifo_wdata <= {1'b0, ~rx_axis_mac_tuser, len_next};
                                state           <= S_IDLE;
                            end
                        end
                    end
                    S_DROP, S_TRUNC: begin
                        if (rx_axis_mac_tlast) state <= S_IDLE;
                    end
                    default: state <= S_SYNC;
                endcase
            end
        end
    end

    // Delivered-frame counter: counts info words as they are written; clear wins.
    always_ff @(posedge rx_clk or negedge rx_reset_n) begin
        if (!rx_reset_n)
            stat_frame_cnt <= '0;
        else if (stat_clr)
            stat_frame_cnt <= '0;
        else if (info_fifo_wren && !(&stat_frame_cnt))
            stat_frame_cnt <= stat_frame_cnt + 1'b1;
    end

    // Dropped-frame counter: counts frames refused at their first beat; clear wins.
    always_ff @(posedge rx_clk or negedge rx_reset_n) begin
        if (!rx_reset_n)
            stat_drop_cnt <= '0;
        else if (stat_clr)
            stat_drop_cnt <= '0;
        else if (drop_inc && !(&stat_drop_cnt))
            stat_drop_cnt <= stat_drop_cnt + 1'b1;
    end

endmodule
